// File: rtl/cnt_run_sched_if.sv
// Request/status bundle for the shared-counter run scheduler.
// master drives requests and abort; slave is the scheduler.
interface cnt_run_sched_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_len;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_len;
  logic             req1_ready;
  logic             abort;
  logic [WIDTH-1:0] cnt_value;
  logic             busy;
  logic             owner;
  logic             done;
  logic             aborted;

  modport master (
    output req0_valid, req0_len,
    output req1_valid, req1_len,
    output abort,
    input  req0_ready, req1_ready,
    input  cnt_value, busy, owner,
    input  done, aborted
  );

  modport slave (
    input  req0_valid, req0_len,
    input  req1_valid, req1_len,
    input  abort,
    output req0_ready, req1_ready,
    output cnt_value, busy, owner,
    output done, aborted
  );
endinterface

// File: rtl/cnt_run_sched.sv
// Round-robin run scheduler for a shared WIDTH-bit counter.
// Define CNT_SCHED_DOWN_EN to count len-1 down to 0 instead of up.
module cnt_run_sched #(
  parameter int WIDTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  cnt_run_sched_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             busy_q, done_q;
  logic             aborted_q, aborted_d;
  logic             gnt0, gnt1, take;
  logic [WIDTH-1:0] acc_len;
  logic             term;

  // Ties go to whichever requester did not own the last run.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      gnt0 = bus.req0_valid &
             (~bus.req1_valid | last_q);
      gnt1 = bus.req1_valid &
             (~bus.req0_valid | ~last_q);
    end
  end

  assign take    = gnt0 | gnt1;
  assign acc_len = gnt1 ? bus.req1_len
                        : bus.req0_len;

`ifdef CNT_SCHED_DOWN_EN
  assign term = (cnt_q == '0);
`else
  assign term = (cnt_q == len_q - ONE);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    owner_d   = owner_q;
    last_d    = last_q;
    aborted_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          len_d   = acc_len;
          owner_d = gnt1;
          last_d  = gnt1;
`ifdef CNT_SCHED_DOWN_EN
          cnt_d = (acc_len == '0) ? '0
                                  : acc_len - ONE;
`else
          cnt_d = '0;
`endif
          state_d = (acc_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (term) begin
          state_d = DONE;
        end else begin
`ifdef CNT_SCHED_DOWN_EN
          cnt_d = cnt_q - ONE;
`else
          cnt_d = cnt_q + ONE;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      aborted_q <= aborted_d;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.cnt_value  = cnt_q;
  assign bus.busy       = busy_q;
  assign bus.owner      = owner_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;
endmodule

// File: tb/tb_cnt_run_sched.sv
// Scoreboard bench for cnt_run_sched: stimulus queues
// expected run results, a monitor checks them on done.
module tb_cnt_run_sched;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   last_m = 1'b1;

  typedef struct {
    int own;
    int ab;
    int cnt;
    int acc;
    int dcyc;
    int len;
  } exp_t;

  exp_t q[$];

  cnt_run_sched_if #(.WIDTH(W)) bus ();

  cnt_run_sched #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int run_cnt(input exp_t e,
                                 input int c);
`ifdef CNT_SCHED_DOWN_EN
    return e.len - 1 - (c - e.acc);
`else
    return c - e.acc;
`endif
  endfunction

  function automatic int fin_cnt(input int len);
`ifdef CNT_SCHED_DOWN_EN
    return 0;
`else
    return (len == 0) ? 0 : len - 1;
`endif
  endfunction

  // Monitor: checks run progress and pops on done.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_excl",
          int'(bus.req0_ready & bus.req1_ready), 0);
      if (bus.busy && !bus.done && q.size() > 0) begin
        chk("run_cnt", int'(bus.cnt_value),
            run_cnt(q[0], cyc));
        chk("run_owner", int'(bus.owner), q[0].own);
      end
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cyc", cyc, e.dcyc);
          chk("done_owner", int'(bus.owner), e.own);
          chk("done_aborted", int'(bus.aborted), e.ab);
          chk("done_cnt", int'(bus.cnt_value), e.cnt);
        end
      end
    end
  end

  task automatic wait_accept(input bit w,
                             output int acc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.req0_ready | bus.req1_ready)
               && n < 60);
    if (!(bus.req0_ready | bus.req1_ready)) begin
      chk("accept_timeout", 0, 1);
      acc = -1;
    end else begin
      chk("grant_winner",
          int'(w ? bus.req1_ready : bus.req0_ready), 1);
      chk("grant_loser",
          int'(w ? bus.req0_ready : bus.req1_ready), 0);
      acc = cyc + 1;
      last_m = w;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input bit w, input int len,
                          input int acc);
    exp_t e;
    e.own  = w;
    e.ab   = 0;
    e.cnt  = fin_cnt(len);
    e.acc  = acc;
    e.dcyc = acc + len;
    e.len  = len;
    q.push_back(e);
  endtask

  initial begin
    int acc;
    int n;
    bit w;
    exp_t e;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_len   = '0;
    bus.req1_len   = '0;
    bus.abort      = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_cnt", int'(bus.cnt_value), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_owner", int'(bus.owner), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_aborted", int'(bus.aborted), 0);
    chk("rst_ready1", int'(bus.req1_ready), 0);
    bus.req0_valid = 1'b1;
    #1;
    chk("rst_ready0_comb", int'(bus.req0_ready), 1);
    bus.req0_valid = 1'b0;
    @(posedge clk);
    #1;

    // Contention: expect grants 0,1,0,1
    bus.req0_len   = 4'd3;
    bus.req1_len   = 4'd2;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = ~last_m;
      chk("rr_order", int'(w), i % 2);
      wait_accept(w, acc);
      push_run(w, w ? 2 : 3, acc);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Single run, len 5
    bus.req0_len   = 4'd5;
    bus.req0_valid = 1'b1;
    wait_accept(1'b0, acc);
    bus.req0_valid = 1'b0;
    push_run(1'b0, 5, acc);

    // Zero length on requester 1
    bus.req1_len   = 4'd0;
    bus.req1_valid = 1'b1;
    wait_accept(1'b1, acc);
    bus.req1_valid = 1'b0;
    push_run(1'b1, 0, acc);

    // Abort while cnt_value == 2
    bus.req0_len   = 4'd10;
    bus.req0_valid = 1'b1;
    wait_accept(1'b0, acc);
    bus.req0_valid = 1'b0;
    e.own  = 0;
    e.ab   = 1;
`ifdef CNT_SCHED_DOWN_EN
    e.cnt  = 7;
`else
    e.cnt  = 2;
`endif
    e.acc  = acc;
    e.dcyc = acc + 3;
    e.len  = 10;
    q.push_back(e);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;

    // Async reset mid-run at cnt_value == 3
    bus.req1_len   = 4'd8;
    bus.req1_valid = 1'b1;
    wait_accept(1'b1, acc);
    bus.req1_valid = 1'b0;
    push_run(1'b1, 8, acc);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2 rst = 1'b1;
    #1;
    q.delete();
    last_m = 1'b1;
    chk("arst_cnt", int'(bus.cnt_value), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_owner", int'(bus.owner), 0);
    chk("arst_done", int'(bus.done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Tie after reset goes to requester 0
    bus.req0_len   = 4'd2;
    bus.req1_len   = 4'd2;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    wait_accept(1'b0, acc);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    push_run(1'b0, 2, acc);

    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
